alu_arbiter: RTL

Sequencer and two-port round-robin arbiter that shares one `alu_8bit` instance between two independent requesters. Each port presents an operand/opcode request on a valid/ready handshake and receives its result on a separate valid/ready response channel. The block registers the operands, drives the ALU for one cycle, captures the result and returns it to the granted port. It sits between the chip I/O decode logic and the ALU datapath.

---
 rtl/alu_arb_pkg.sv | 19 +
 rtl/alu_arbiter_if.sv | 22 ++
 rtl/alu_8bit.sv | 19 +
 rtl/alu_rr_arbiter.sv | 12 +
 rtl/alu_arbiter.sv | 96 +++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared FSM state, opcode and port-count definitions for the ALU arbiter slice.
package alu_arb_pkg;
    localparam int NPORT = 2;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;

    function automatic logic [NPORT-1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: two-port request/response bundle; master = requesters, slave = arbiter.
interface alu_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [5:0]  req_op;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [7:0]  rsp_result;
    logic        rsp_cout;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_cout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_cout
    );
endinterface

// File: rtl/alu_8bit.sv
// alu_8bit: combinational 8-bit ALU; add/sub/and/or, opcodes 1xx give zero.
module alu_8bit
    import alu_arb_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    output logic [7:0] result,
    output logic       cout
);
    logic [8:0] sum;

    assign sum    = {1'b0, a} + {1'b0, b};
    assign result = op == OP_ADD ? sum[7:0] :
                    op == OP_SUB ? a - b :
                    op == OP_AND ? a & b :
                    op == OP_OR  ? a | b : 8'h00;
    assign cout   = op == OP_ADD && sum[8];
endmodule

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: two-input round-robin pick; prio names the winner on contention.
module alu_rr_arbiter
    import alu_arb_pkg::*;
(
    input  logic [NPORT-1:0] req,
    input  logic             prio,
    output logic [NPORT-1:0] grant,
    output logic             win
);
    assign win   = &req ? prio : req[1];
    assign grant = |req ? onehot(win) : '0;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu_8bit between two valid/ready requesters with round-robin priority.
// Define ALU_ARB_STATS_EN to add saturating per-port grant counters on grant_cnt.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int STAT_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus,
    output logic         busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NPORT*STAT_W-1:0] grant_cnt
`endif
);
    state_t           state;
    logic             prio, owner, win;
    logic [NPORT-1:0] grant, rsp_valid;
    logic [7:0]       op_a, op_b, alu_res, rsp_result;
    logic [2:0]       op_code;
    logic             alu_cout, rsp_cout;

    if (STAT_W < 1) begin : g_bad_stat_w
        $error("STAT_W must be at least 1");
    end

    alu_rr_arbiter u_arb (
        .req  (bus.req_valid),
        .prio (prio),
        .grant(grant),
        .win  (win)
    );

    alu_8bit u_alu (
        .a     (op_a),
        .b     (op_b),
        .op    (op_code),
        .result(alu_res),
        .cout  (alu_cout)
    );

    // rst_n gating holds req_ready at zero for the whole reset, not just after the first edge
    assign bus.req_ready  = (state == IDLE && rst_n) ? grant : '0;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_result = rsp_result;
    assign bus.rsp_cout   = rsp_cout;
    assign busy           = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prio       <= 1'b0;
            owner      <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_code    <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|bus.req_valid) begin
                    owner   <= win;
                    op_a    <= win ? bus.req_a[15:8] : bus.req_a[7:0];
                    op_b    <= win ? bus.req_b[15:8] : bus.req_b[7:0];
                    op_code <= win ? bus.req_op[5:3] : bus.req_op[2:0];
                    state   <= EXEC;
                end
                EXEC: begin
                    rsp_result <= alu_res;
                    rsp_cout   <= alu_cout;
                    rsp_valid  <= onehot(owner);
                    state      <= RESP;
                end
                RESP: if (bus.rsp_ready[owner]) begin
                    rsp_valid <= '0;
                    prio      <= !owner;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    for (genvar i = 0; i < NPORT; i++) begin : g_cnt
        logic [STAT_W-1:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt <= '0;
            else if (bus.req_valid[i] && bus.req_ready[i] && !(&cnt)) cnt <= cnt + 1'b1;
        end
        assign grant_cnt[i*STAT_W +: STAT_W] = cnt;
    end
`endif
endmodule
